// File: rtl/datamem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
// Owner encoding, port indices and counter sizing.
package datamem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } arb_state_t;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;

  function automatic int cnt_w(input int lim);
    return $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/datamem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// One instance per port; the arbiter takes the slave side.
interface datamem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/datamem_arbiter_sat_counter.sv
// Saturating up-counter with clear and at-limit flag.
// clr together with inc restarts the count at one.
module arb_sat_counter
  import datamem_arb_pkg::*;
#(
  parameter int LIMIT = 4,
  parameter int W     = cnt_w(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam logic [W-1:0] LIM = W'(LIMIT);
  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= i_inc ? ONE : '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_at_limit = (r_cnt == LIM);

endmodule

// File: rtl/datamem_arbiter.sv
// Single-port data-memory arbiter: CPU priority,
// DMA burst allowance and starvation guard.
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_BURST     = 4,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  datamem_arbiter_if.slave         cpu_if,
  datamem_arbiter_if.slave         dma_if,
  output logic [ADDRESS_WIDTH-1:0] o_mem_a,
  output logic [DATA_WIDTH-1:0]    o_mem_wd,
  output logic                     o_mem_we,
  input  logic [DATA_WIDTH-1:0]    i_mem_rd
);

  arb_state_t r_state;
  arb_state_t w_next;

  logic w_gnt0;
  logic w_gnt1;
  logic w_both;
  logic w_dma_pri;
  logic w_burst_lim;
  logic w_starve_lim;
  logic w_burst_clr;
  logic w_starve_inc;
  logic w_starve_clr;
  logic w_rd0;
  logic w_rd1;

  logic                  r_rvalid0;
  logic                  r_rvalid1;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  assign w_both    = cpu_if.req & dma_if.req;
  assign w_dma_pri = ((r_state == OWN_DMA) && !w_burst_lim)
                   || w_starve_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = IDLE;
    unique case (1'b1)
      w_gnt0:  w_next = OWN_CPU;
      w_gnt1:  w_next = OWN_DMA;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    unique case (1'b1)
      w_both &  w_dma_pri:       w_gnt1 = 1'b1;
      w_both & !w_dma_pri:       w_gnt0 = 1'b1;
      cpu_if.req & !dma_if.req:  w_gnt0 = 1'b1;
      dma_if.req & !cpu_if.req:  w_gnt1 = 1'b1;
      default: begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
      end
    endcase
  end

  // Idle cycles still present port 0 to the memory.
  always_comb begin
    o_mem_a  = w_gnt1 ? dma_if.addr  : cpu_if.addr;
    o_mem_wd = w_gnt1 ? dma_if.wdata : cpu_if.wdata;
    o_mem_we = (w_gnt0 & cpu_if.we) | (w_gnt1 & dma_if.we);
  end

  // A grant from any other owner restarts the burst at one.
  assign w_burst_clr  = !w_gnt1 || (r_state != OWN_DMA);
  assign w_starve_inc = dma_if.req & !w_gnt1;
  assign w_starve_clr = w_gnt1 | !dma_if.req;

  arb_sat_counter #(
    .LIMIT (MAX_BURST)
  ) u_burst (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_gnt1),
    .i_clr      (w_burst_clr),
    .o_at_limit (w_burst_lim)
  );

  arb_sat_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_inc      (w_starve_inc),
    .i_clr      (w_starve_clr),
    .o_at_limit (w_starve_lim)
  );

  assign w_rd0 = w_gnt0 & !cpu_if.we;
  assign w_rd1 = w_gnt1 & !dma_if.we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0  <= '0;
      r_rdata1  <= '0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) r_rdata0 <= i_mem_rd;
      if (w_rd1) r_rdata1 <= i_mem_rd;
    end
  end

  assign cpu_if.gnt    = w_gnt0;
  assign dma_if.gnt    = w_gnt1;
  assign cpu_if.rvalid = r_rvalid0;
  assign dma_if.rvalid = r_rvalid1;
  assign cpu_if.rdata  = r_rdata0;
  assign dma_if.rdata  = r_rdata1;

endmodule

// File: tb/tb_datamem_arbiter.sv
// Bench for datamem_arbiter: directed scenarios plus
// random traffic against a rule-level reference model.
module tb_datamem_arbiter;
  import datamem_arb_pkg::*;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXB = 4;
  localparam int STV  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datamem_arbiter_if #(.AW(AW), .DW(DW)) cpu ();
  datamem_arbiter_if #(.AW(AW), .DW(DW)) dma ();

  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          mem_we;

  datamem_arbiter #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .MAX_BURST     (MAXB),
    .STARVE_LIMIT  (STV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_if   (cpu),
    .dma_if   (dma),
    .o_mem_a  (mem_a),
    .o_mem_wd (mem_wd),
    .o_mem_we (mem_we),
    .i_mem_rd (mem_rd)
  );

  logic [DW-1:0] ram [256] = '{default: '0};
  always @(posedge clk) if (mem_we) ram[mem_a[7:0]] <= mem_wd;
  assign mem_rd = ram[mem_a[7:0]];

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] ref_mem [256] = '{default: '0};
  int            m_owner;
  int            m_burst;
  int            m_starve;
  logic          m_rv0, m_rv1;
  logic [DW-1:0] m_rd0, m_rd1;
  logic          obs_g0, obs_g1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_burst = 0; m_starve = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0;
    m_rd0 = '0;   m_rd1 = '0;
  endtask

  task automatic set0(input logic r, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu.req = r; cpu.we = w; cpu.addr = a; cpu.wdata = d;
  endtask

  task automatic set1(input logic r, input logic w,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
    dma.req = r; dma.we = w; dma.addr = a; dma.wdata = d;
  endtask

  // One clock: check combinational outputs, advance model, check registers.
  task automatic cyc();
    logic g0, g1, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    #1;
    if (cpu.req && dma.req) begin
      g1 = (m_owner == 2 && m_burst < MAXB) || (m_starve >= STV);
      g0 = !g1;
    end else begin
      g0 = cpu.req;
      g1 = dma.req;
    end
    ea  = g1 ? dma.addr  : cpu.addr;
    ewd = g1 ? dma.wdata : cpu.wdata;
    ewe = (g0 & cpu.we) | (g1 & dma.we);
    obs_g0 = cpu.gnt;
    obs_g1 = dma.gnt;
    chk("gnt0", cpu.gnt, g0);
    chk("gnt1", dma.gnt, g1);
    chk("mem_we", mem_we, ewe);
    chk("mem_a", mem_a, ea);
    chk("mem_wd", mem_wd, ewd);
    m_rv0 = g0 & !cpu.we;
    m_rv1 = g1 & !dma.we;
    if (m_rv0) m_rd0 = ref_mem[ea[7:0]];
    if (m_rv1) m_rd1 = ref_mem[ea[7:0]];
    if (ewe) ref_mem[ea[7:0]] = ewd;
    if (g1) m_burst = (m_owner == 2) ?
                      ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 1;
    else    m_burst = 0;
    if (dma.req && !g1) m_starve = (m_starve + 1 > STV) ? STV : m_starve + 1;
    else                m_starve = 0;
    m_owner = g0 ? 1 : (g1 ? 2 : 0);
    @(posedge clk);
    #1;
    chk("rvalid0", cpu.rvalid, m_rv0);
    chk("rvalid1", dma.rvalid, m_rv1);
    chk("rdata0", cpu.rdata, m_rd0);
    chk("rdata1", dma.rdata, m_rd1);
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    cyc();
  endtask

  initial begin
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    model_reset();
    obs_g0 = 1'b0;
    obs_g1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid0", cpu.rvalid, 1'b0);
    chk("rst_rvalid1", dma.rvalid, 1'b0);
    chk("rst_rdata0", cpu.rdata, '0);
    chk("rst_rdata1", dma.rdata, '0);
    chk("rst_state", dut.r_state, IDLE);
    rst_n = 1'b1;

    // Single CPU write then read-back.
    set0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    cyc();
    chk("cpu_wr_gnt", obs_g0, 1'b1);
    chk("cpu_wr_norv", cpu.rvalid, 1'b0);
    set0(1'b1, 1'b0, 32'h10, '0);
    cyc();
    chk("cpu_rd_gnt", obs_g0, 1'b1);
    chk("cpu_rd_rv", cpu.rvalid, 1'b1);
    chk("cpu_rd_data", cpu.rdata, 32'hDEADBEEF);
    idle();

    // Burst cap: CPU joins on DMA's second grant.
    set1(1'b1, 1'b0, 32'h30, '0);
    cyc();
    chk("burst_g1_1", obs_g1, 1'b1);
    set0(1'b1, 1'b0, 32'h40, '0);
    for (int i = 2; i <= MAXB; i++) begin
      cyc();
      chk("burst_g1_n", obs_g1, 1'b1);
    end
    cyc();
    chk("burst_cap_g0", obs_g0, 1'b1);
    idle();

    // Starvation guard from IDLE.
    set0(1'b1, 1'b0, 32'h44, '0);
    set1(1'b1, 1'b0, 32'h48, '0);
    for (int i = 1; i <= STV + MAXB + 1; i++) begin
      cyc();
      chk("starve_g1", obs_g1, (i > STV && i <= STV + MAXB));
      if (i == STV + 1) chk("starve_clr", dut.u_starve.r_cnt, '0);
    end
    idle();

    // Contention on one address, then CPU reads it back.
    set0(1'b1, 1'b1, 32'h20, 32'h1);
    set1(1'b1, 1'b1, 32'h20, 32'h2);
    cyc();
    chk("cont_cpu_first", obs_g0, 1'b1);
    set0(1'b0, 1'b0, '0, '0);
    cyc();
    chk("cont_dma_next", obs_g1, 1'b1);
    set1(1'b0, 1'b0, '0, '0);
    set0(1'b1, 1'b0, 32'h20, '0);
    cyc();
    chk("cont_rdata", cpu.rdata, 32'h2);
    idle();

    // DMA abandons its request while the CPU owns the memory.
    set0(1'b1, 1'b0, 32'h50, '0);
    cyc();
    set1(1'b1, 1'b0, 32'h60, '0);
    cyc();
    chk("aband_nog1", obs_g1, 1'b0);
    set1(1'b0, 1'b0, '0, '0);
    cyc();
    chk("aband_rv1", dma.rvalid, 1'b0);
    chk("aband_starve", dut.u_starve.r_cnt, '0);
    idle();

    // Random traffic; unserved requests mostly hold, sometimes drop.
    for (int n = 0; n < 400; n++) begin
      if (!(cpu.req && !obs_g0 && $urandom_range(0, 4) != 0))
        set0($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), $urandom);
      if (!(dma.req && !obs_g1 && $urandom_range(0, 4) != 0))
        set1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
             AW'($urandom_range(0, 15)), $urandom);
      cyc();
    end
    idle();

    // Reset asserted while a read grant is active.
    set0(1'b1, 1'b1, 32'h70, 32'h12345678);
    cyc();
    set0(1'b1, 1'b0, 32'h70, '0);
    cyc();
    chk("pre_rst_rdata", cpu.rdata, 32'h12345678);
    #1;
    chk("pre_rst_gnt", cpu.gnt, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_rvalid0", cpu.rvalid, 1'b0);
    chk("arst_rdata0", cpu.rdata, '0);
    @(posedge clk);
    #1;
    chk("rst_hold_rv0", cpu.rvalid, 1'b0);
    chk("rst_hold_rv1", dma.rvalid, 1'b0);
    chk("rst_hold_rd1", dma.rdata, '0);
    chk("rst_hold_st", dut.r_state, IDLE);
    set0(1'b0, 1'b0, '0, '0);
    set1(1'b0, 1'b0, '0, '0);
    #2;
    rst_n = 1'b1;
    model_reset();
    idle();
    chk("post_rst_st", dut.r_state, IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/datamem_arbiter.md
Name: datamem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU MEM stage) and port 1 (DMA/loader).
- Grants one access per cycle and drives the memory's address, write-data and write-enable inputs.
- Returns registered read data one cycle after grant.
- CPU has priority, bounded by a DMA burst allowance and a DMA starvation limit.

Parameters:
- ADDRESS_WIDTH, 32, width of requester and memory addresses.
- DATA_WIDTH, 32, width of read/write data.
- MAX_BURST, 4, max consecutive DMA grants while CPU is also requesting; legal ≥1.
- STARVE_LIMIT, 8, consecutive denied DMA request cycles before DMA is forced a grant; legal ≥1.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req0, req1  in  1  access request, ports 0/1.
- we0, we1  in  1  1=write, 0=read; qualified by req.
- addr0, addr1  in  ADDRESS_WIDTH  access address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- gnt0, gnt1  out  1  combinational grant this cycle; access completes at the next posedge.
- rvalid0, rvalid1  out  1  registered; high for one cycle after a granted read.
- rdata0, rdata1  out  DATA_WIDTH  registered read data; holds its value until the next granted read on that port.
- mem_a  out  ADDRESS_WIDTH  to memory A.
- mem_wd  out  DATA_WIDTH  to memory WD.
- mem_we  out  1  to memory WE.
- mem_rd  in  DATA_WIDTH  combinational read data from memory.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, burst_cnt=0, starve_cnt=0.
  - rvalid0/1=0, rdata0/1=0.
  - Pending read responses are dropped.
- FSM records the last owner:
  - IDLE: no grant last cycle.
  - OWN_CPU: port 0 granted last cycle.
  - OWN_DMA: port 1 granted last cycle.
  - Next state = owner of the current cycle's grant, or IDLE if none.
- Grant rules (combinational, at most one of gnt0/gnt1 high):
  - Only req0 set → gnt0. Only req1 set → gnt1. Neither → no grant.
  - Both set → gnt1 if (state==OWN_DMA and burst_cnt<MAX_BURST) or starve_cnt==STARVE_LIMIT; else gnt0.
- Memory muxing:
  - mem_a/mem_wd follow the granted port's addr/wdata.
  - With no grant, mem_a/mem_wd follow port 0.
  - mem_we = granted port's we; mem_we=0 when nothing is granted.
- burst_cnt:
  - On gnt1: burst_cnt = (state==OWN_DMA ? burst_cnt+1 : 1), saturating at MAX_BURST.
  - Cleared on any cycle without gnt1.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when req1 && !gnt1.
  - Cleared when gnt1 or !req1.
  - A forced grant clears it.
- Read response:
  - On posedge after a granted read on port i: rdata_i<=mem_rd, rvalid_i<=1.
  - Otherwise rvalid_i<=0.
  - Writes never raise rvalid.
- Read-after-write: a write granted in cycle N commits at posedge N. A read of the same address granted in cycle N+1 returns the new data.
- Simultaneous requests to the same address: only the granted access occurs. The loser holds its request, and the access order is the grant order.
- Requesters must hold req/we/addr/wdata stable until gnt is seen. Dropping req before gnt is legal; the access is abandoned and no response is produced.
- No combinational path from mem_rd to any output except through rdata registers.
- Arithmetic: counters sized $clog2(limit+1); no wrap, saturate only.

Decomposition:
- Shared package datamem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, OWN_CPU, OWN_DMA} arb_state_t.
  - Port index localparams PORT_CPU=0, PORT_DMA=1.
- Sub-module arb_sat_counter: saturating counter with inc/clr/limit inputs and an at_limit flag. Instantiated twice, for burst_cnt and starve_cnt.

Test Plan:
- Reset: rst_n low mid-read (grant active) → after release, rvalid0/1=0, rdata0/1=0, state IDLE, no spurious mem_we.
- Single CPU: req0 write 0xDEADBEEF to addr 0x10, then read 0x10 → gnt0 both cycles; mem_we=1 only in the first cycle; rvalid0=1 with rdata0=0xDEADBEEF one cycle after the read grant.
- Burst cap: req1 held continuously, req0 raised on DMA's 2nd grant, MAX_BURST=4 → DMA gets grants 1-4, then gnt0 on the next cycle.
- Starvation: req0 and req1 held continuously from IDLE, STARVE_LIMIT=8 → gnt0 for 8 cycles, gnt1 on the 9th, starve_cnt back to 0, then gnt1 continues per burst rule up to 4 total.
- Contention: both write the same addr 0x20 (CPU 0x1, DMA 0x2) in the same cycle, then CPU reads 0x20 → CPU granted first, DMA next; the read returns 0x2.
- Abandon: req1 raised then dropped before grant while CPU owns → no gnt1, rvalid1 stays 0, starve_cnt cleared.
